// File: rtl/mux4to1_rr_merge.sv
// Four-to-one valid/ready merge with a registered output beat tagged by source index.
// Round-robin by default; define MUX4_FIXED_PRIO_EN for fixed priority (ch0 highest).
module mux4to1_rr_merge #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0] ptr;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       any;
  logic       load;

`ifdef MUX4_FIXED_PRIO_EN
  assign ptr = 2'b00;
`else
  // Priority pointer moves only on acceptance, to one past the winner.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 2'b00;
    else if (load && any)
      ptr <= sel + 2'd1;
  end
`endif

  // First requester found searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    logic [1:0] idx;
    gnt = 4'b0000;
    sel = 2'b00;
    any = 1'b0;
    idx = 2'b00;
    for (int o = 0; o < 4; o++) begin
      idx = ptr + 2'(o);
      if (!any && in_valid[idx]) begin
        gnt[idx] = 1'b1;
        sel      = idx;
        any      = 1'b1;
      end
    end
  end

  assign load     = ~out_valid | out_ready;
  assign in_ready = gnt & {4{load & ~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'b00;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[sel*WIDTH +: WIDTH];
        out_sel  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mux4to1_rr_merge.sv
// Self-checking bench for mux4to1_rr_merge: directed scenarios then randomized traffic
// against a transaction-level model of the merge (pointer, output slot).
module tb_mux4to1_rr_merge;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  mux4to1_rr_merge #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_ptr = 0;
  bit         m_ov  = 0;
  int         m_d   = 0;
  int         m_sel = 0;
  logic [3:0] m_rdy;
  logic [3:0] seen_rdy;

`ifdef MUX4_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check grant before the edge, advance model, check outputs after.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [4*W-1:0] d, input logic ordy);
    int k;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    m_rdy = 4'b0000;
    k = -1;
    if (!r && (!m_ov || ordy)) begin
      for (int o = 0; o < 4; o++)
        if (k < 0 && v[(m_ptr + o) % 4]) k = (m_ptr + o) % 4;
      if (k >= 0) m_rdy[k] = 1'b1;
    end
    seen_rdy = in_ready;
    chk("in_ready", {28'd0, in_ready}, {28'd0, m_rdy});
    if (r) begin
      m_ov = 0; m_d = 0; m_sel = 0; m_ptr = 0;
    end else if (!m_ov || ordy) begin
      if (k >= 0) begin
        m_ov  = 1;
        m_d   = int'(d[k*W +: W]);
        m_sel = k;
        m_ptr = RR ? (k + 1) % 4 : 0;
      end else begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data",  {24'd0, out_data},  m_d);
    chk("out_sel",   {30'd0, out_sel},   m_sel);
  endtask

  logic [4*W-1:0] all_d;
  bit             pv [4];
  logic [W-1:0]   pd [4];

  initial begin
    logic [3:0]     v;
    logic [4*W-1:0] d;
    rst = 1'b1; in_valid = 4'b0; in_data = '0; out_ready = 1'b0;
    all_d = {8'h13, 8'h12, 8'h11, 8'h10};

    // T1 reset with every channel requesting
    repeat (2) begin
      cycle(1'b1, 4'b1111, all_d, 1'b1);
      chk("t1_ready", {28'd0, seen_rdy}, 32'd0);
      chk("t1_valid", {31'd0, out_valid}, 32'd0);
    end

    // T3 rotation, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 4'b1111, all_d, 1'b1);
      chk("t3_sel", {30'd0, out_sel}, RR ? (i % 4) : 0);
      chk("t3_valid", {31'd0, out_valid}, 32'd1);
    end

    // T2 single channel
    cycle(1'b0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1);
    chk("t2_ready", {28'd0, seen_rdy}, 32'h4);
    chk("t2_data", {24'd0, out_data}, 32'hA5);
    chk("t2_sel", {30'd0, out_sel}, 32'd2);

    // T4 backpressure: load a beat, stall 5 cycles, then drain and refill from ch3
    cycle(1'b0, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h5C}, 1'b1);
    repeat (5) begin
      cycle(1'b0, 4'b1000, {8'h77, 24'h0}, 1'b0);
      chk("t4_stall_ready", {28'd0, seen_rdy}, 32'd0);
      chk("t4_hold_data", {24'd0, out_data}, 32'h5C);
    end
    cycle(1'b0, 4'b1000, {8'h77, 24'h0}, 1'b1);
    chk("t4_refill_ready", {28'd0, seen_rdy}, 32'h8);
    chk("t4_refill_sel", {30'd0, out_sel}, 32'd3);

    // T5 wrap: ch3 just accepted, so ch0 wins next
    cycle(1'b0, 4'b1001, {8'h33, 16'h0, 8'h44}, 1'b1);
    chk("t5_ready", {28'd0, seen_rdy}, 32'h1);

    // T6 reset with a stalled beat
    cycle(1'b0, 4'b0010, {16'h0, 8'h66, 8'h0}, 1'b1);
    cycle(1'b0, 4'b0000, all_d, 1'b0);
    cycle(1'b1, 4'b0000, all_d, 1'b0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 4'b1111, all_d, 1'b1);
    chk("t6_ready", {28'd0, seen_rdy}, 32'h1);

    // randomized traffic; channels hold valid/data until accepted
    for (int k = 0; k < 4; k++) begin pv[k] = 0; pd[k] = '0; end
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++)
        if (!pv[k] && ($urandom % 2 == 0)) begin
          pv[k] = 1;
          pd[k] = W'($urandom);
        end
      v = 4'b0; d = '0;
      for (int k = 0; k < 4; k++) begin
        v[k] = pv[k];
        d[k*W +: W] = pd[k];
      end
      cycle(($urandom % 40) == 0, v, d, ($urandom % 4) != 0);
      for (int k = 0; k < 4; k++) if (m_rdy[k]) pv[k] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
